// File: rtl/bcd_to_binary_3_digits.sv
// bcd_to_binary_3_digits
// Converts a three-digit BCD value (000..999) to a 10-bit binary value using
// reverse double-dabble: each step shifts the work register right by one, then
// subtracts 3 from every BCD digit field that has reached 8 or more.
// A start/busy/done handshake fronts the converter, with one step per clock.

module bcd_to_binary_3_digits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] D2,
    input  logic [3:0] D1,
    input  logic [3:0] D0,
    output logic       busy,
    output logic       done,
    output logic [9:0] bin,
    output logic       error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // The last step is the one taken while the counter holds this value
    localparam logic [3:0] LAST_STEP = 4'd9;

    logic [1:0]  r_state;
    logic [21:0] r_work;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [9:0]  r_bin;
    logic        r_error;

    logic        w_digitInvalid;
    logic [21:0] w_shifted;
    logic [21:0] w_stepped;

    // Flag a capture request whose digits are not legal BCD
    always_comb begin
        w_digitInvalid = (D2 > 4'd9) || (D1 > 4'd9) || (D0 > 4'd9);
    end

    // One conversion step: shift right, then correct each digit field on its own
    always_comb begin
        w_shifted = r_work >> 1;
        w_stepped = w_shifted;
        if (w_shifted[21:18] >= 4'd8) begin
            w_stepped[21:18] = w_shifted[21:18] - 4'd3;
        end
        if (w_shifted[17:14] >= 4'd8) begin
            w_stepped[17:14] = w_shifted[17:14] - 4'd3;
        end
        if (w_shifted[13:10] >= 4'd8) begin
            w_stepped[13:10] = w_shifted[13:10] - 4'd3;
        end
    end

    // Control FSM plus work register, step counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_work  <= 22'd0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bin   <= 10'd0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (w_digitInvalid) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_bin   <= 10'd0;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_work  <= {D2, D1, D0, 10'd0};
                            r_cnt   <= 4'd0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_stepped;
                    r_cnt  <= r_cnt + 4'd1;
                    if (r_cnt == LAST_STEP) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_bin   <= w_stepped[9:0];
                        r_error <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign bin   = r_bin;
    assign error = r_error;

endmodule

// File: tb/tb_bcd_to_binary_3_digits.sv
// tb_bcd_to_binary_3_digits
// Directed bench for the three-digit BCD to binary converter. A cycle-level
// behavioural model (decimal arithmetic plus a countdown to the done cycle)
// is compared against the DUT outputs on every falling clock edge, and the
// directed cases also pin the results against hand-computed literals.

module tb_bcd_to_binary_3_digits;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] D2;
    logic [3:0] D1;
    logic [3:0] D0;
    logic       busy;
    logic       done;
    logic [9:0] bin;
    logic       error;

    int checkCount = 0;
    int passCount  = 0;
    bit checkEn    = 1'b0;

    // Model state
    logic mBusy;
    logic mDone;
    int   mBin;
    logic mErr;
    int   mRemain;
    int   mPending;

    bcd_to_binary_3_digits dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .D2    (D2),
        .D1    (D1),
        .D0    (D0),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .error (error)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and report a FAIL line on disagreement
    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a valid request yields the decimal value 10 edges later,
    // an invalid one yields error on the very next state; done lasts one cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy    <= 1'b0;
            mDone    <= 1'b0;
            mBin     <= 0;
            mErr     <= 1'b0;
            mRemain  <= 0;
            mPending <= 0;
        end else if (mRemain != 0) begin
            mRemain <= mRemain - 1;
            if (mRemain == 1) begin
                mBusy <= 1'b0;
                mDone <= 1'b1;
                mBin  <= mPending;
                mErr  <= 1'b0;
            end
        end else if (mDone) begin
            mDone <= 1'b0;
        end else if (start) begin
            if (D2 > 4'd9 || D1 > 4'd9 || D0 > 4'd9) begin
                mDone <= 1'b1;
                mErr  <= 1'b1;
                mBin  <= 0;
            end else begin
                mPending <= int'(D2) * 100 + int'(D1) * 10 + int'(D0);
                mRemain  <= 10;
                mBusy    <= 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (checkEn && rst_n) begin
            checkOutput("modelBusy",  int'(busy),  int'(mBusy));
            checkOutput("modelDone",  int'(done),  int'(mDone));
            checkOutput("modelBin",   int'(bin),   mBin);
            checkOutput("modelError", int'(error), int'(mErr));
        end
    end

    // Present digits with a one-cycle start pulse; called and returns on a falling edge
    task automatic applyStimulus(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
        D2    = d2;
        D1    = d1;
        D0    = d0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; latency counts edges after the sampling edge
    task automatic waitDone(output int latency, output int busyCycles);
        latency    = 0;
        busyCycles = 0;
        while (!done && latency < 20) begin
            if (busy) busyCycles++;
            @(negedge clk);
            latency++;
        end
        if (!done) checkOutput("doneTimeout", 0, 1);
    endtask

    // Full directed conversion with literal expectations
    task automatic runConversion(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                                 input int expBin, input int expErr,
                                 input int expLatency, input int expBusy);
        int lat;
        int bc;
        applyStimulus(d2, d1, d0);
        waitDone(lat, bc);
        checkOutput($sformatf("bin_%0d%0d%0d", d2, d1, d0), int'(bin), expBin);
        checkOutput($sformatf("error_%0d%0d%0d", d2, d1, d0), int'(error), expErr);
        checkOutput($sformatf("latency_%0d%0d%0d", d2, d1, d0), lat, expLatency);
        checkOutput($sformatf("busyCycles_%0d%0d%0d", d2, d1, d0), bc, expBusy);
        @(negedge clk);
        checkOutput($sformatf("donePulseWidth_%0d%0d%0d", d2, d1, d0), int'(done), 0);
    endtask

    initial begin
        int dones;
        int doneAt[$];

        rst_n = 1'b1;
        start = 1'b0;
        D2    = 4'd0;
        D1    = 4'd0;
        D0    = 4'd0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("resetBusy",  int'(busy),  0);
        checkOutput("resetDone",  int'(done),  0);
        checkOutput("resetBin",   int'(bin),   0);
        checkOutput("resetError", int'(error), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        checkEn = 1'b1;
        @(negedge clk);

        // Range ends and mid values
        runConversion(4'd9, 4'd9, 4'd9, 999, 0, 10, 10);
        runConversion(4'd0, 4'd0, 4'd0, 0,   0, 10, 10);
        runConversion(4'd2, 4'd5, 4'd5, 255, 0, 10, 10);
        runConversion(4'd5, 4'd1, 4'd2, 512, 0, 10, 10);
        runConversion(4'd1, 4'd0, 4'd0, 100, 0, 10, 10);

        // Invalid digit, then a valid conversion clears error
        runConversion(4'd0, 4'hA, 4'd0, 0,  1, 0, 0);
        runConversion(4'd0, 4'd4, 4'd2, 42, 0, 10, 10);

        // Asynchronous reset in the middle of a conversion
        applyStimulus(4'd9, 4'd9, 4'd9);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midResetBusy",  int'(busy),  0);
        checkOutput("midResetDone",  int'(done),  0);
        checkOutput("midResetBin",   int'(bin),   0);
        checkOutput("midResetError", int'(error), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("abortedDoneCount", dones, 0);
        checkOutput("abortedBin", int'(bin), 0);
        checkOutput("abortedBusy", int'(busy), 0);
        runConversion(4'd0, 4'd0, 4'd1, 1, 0, 10, 10);

        // Start and digit changes during a conversion are ignored
        D2    = 4'd1;
        D1    = 4'd2;
        D0    = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        D2    = 4'd7;
        D1    = 4'd7;
        D0    = 4'd7;
        dones = 0;
        for (int c = 1; c < 26; c++) begin
            if (done) dones++;
            start = (c == 3 || c == 10);
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("handshakeDoneCount", dones, 1);
        checkOutput("handshakeBin", int'(bin), 123);

        // Start held high: a fresh conversion every 12 cycles
        D2    = 4'd3;
        D1    = 4'd0;
        D0    = 4'd0;
        start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                doneAt.push_back(c);
                checkOutput($sformatf("backToBackBin_%0d", c), int'(bin), 300);
            end else if (doneAt.size() != 0) begin
                checkOutput($sformatf("backToBackHold_%0d", c), int'(bin), 300);
            end
        end
        start = 1'b0;
        checkOutput("backToBackCount", doneAt.size(), 3);
        if (doneAt.size() >= 3) begin
            checkOutput("backToBackFirst", doneAt[0], 10);
            checkOutput("backToBackGap1", doneAt[1] - doneAt[0], 12);
            checkOutput("backToBackGap2", doneAt[2] - doneAt[1], 12);
        end
        repeat (14) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
